// File: rtl/udma_hyper_trans_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | udma_hyper_trans_sched: round-robin descriptor scheduler for HyperBus DMA  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module udma_hyper_trans_sched #(
  parameter  int NB_CH          = 2,
  parameter  int L2_AWIDTH_NOAL = 12,
  parameter  int TRANS_SIZE     = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NB_CH),
  localparam int CNT_W          = $clog2(NB_CH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_CH-1:0]               req_valid_i,
  output logic [NB_CH-1:0]               req_ready_o,
  input  logic [NB_CH*32-1:0]            req_hyper_addr_i,
  input  logic [NB_CH*L2_AWIDTH_NOAL-1:0] req_l2_addr_i,
  input  logic [NB_CH*TRANS_SIZE-1:0]    req_size_i,
  input  logic [NB_CH-1:0]               req_rw_i,
  output logic                           trans_valid_o,
  input  logic                           trans_ready_i,
  output logic [31:0]                    trans_hyper_addr_o,
  output logic [L2_AWIDTH_NOAL-1:0]      trans_l2_addr_o,
  output logic [TRANS_SIZE-1:0]          trans_size_o,
  output logic                           trans_rw_o,
  output logic [ID_W-1:0]                trans_id_o,
  input  logic                           trans_done_i,
  output logic [NB_CH-1:0]               done_o,
  output logic                           timeout_o,
  output logic [ID_W-1:0]                err_id_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               nb_trans_waiting_o
);

  localparam int  TMR_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                    state_q;
  logic [ID_W-1:0]           rr_ptr_q;
  logic [ID_W-1:0]           rr_ptr_d;
  logic [TMR_W-1:0]          timer_q;
  logic                      trans_valid_q;
  logic [31:0]               haddr_q;
  logic [L2_AWIDTH_NOAL-1:0] l2_q;
  logic [TRANS_SIZE-1:0]     size_q;
  logic                      rw_q;
  logic [ID_W-1:0]           id_q;
  logic [NB_CH-1:0]          done_q;
  logic                      timeout_q;
  logic [ID_W-1:0]           err_id_q;
  logic                      busy_q;

  logic                      sel_vld;
  logic [ID_W-1:0]           sel_id;
  logic [31:0]               sel_haddr;
  logic [L2_AWIDTH_NOAL-1:0] sel_l2;
  logic [TRANS_SIZE-1:0]     sel_size;
  logic                      sel_rw;
  logic [CNT_W-1:0]          nb_waiting;

  // Scan from the highest offset down so the channel closest to rr_ptr wins last.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      if (req_valid_i[(int'(rr_ptr_q) + i) % NB_CH]) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'((int'(rr_ptr_q) + i) % NB_CH);
      end
    end
  end

  always_comb begin
    rr_ptr_d = (int'(sel_id) == NB_CH - 1) ? '0 : sel_id + 1'b1;
  end

  always_comb begin
    sel_haddr = '0;
    sel_l2    = '0;
    sel_size  = '0;
    sel_rw    = 1'b0;
    for (int c = 0; c < NB_CH; c++) begin
      if (sel_id == ID_W'(c)) begin
        sel_haddr = req_hyper_addr_i[c*32 +: 32];
        sel_l2    = req_l2_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        sel_size  = req_size_i[c*TRANS_SIZE +: TRANS_SIZE];
        sel_rw    = req_rw_i[c];
      end
    end
  end

  always_comb begin
    nb_waiting = '0;
    for (int c = 0; c < NB_CH; c++) begin
      nb_waiting = nb_waiting + CNT_W'(req_valid_i[c]);
    end
  end

  // Acceptance is suppressed under reset because the edge would not latch the descriptor.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && sel_vld && !rst_i) begin
      req_ready_o[sel_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      trans_valid_q <= 1'b0;
      haddr_q       <= '0;
      l2_q          <= '0;
      size_q        <= '0;
      rw_q          <= 1'b0;
      id_q          <= '0;
      done_q        <= '0;
      timeout_q     <= 1'b0;
      err_id_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_vld) begin
            haddr_q       <= sel_haddr;
            l2_q          <= sel_l2;
            size_q        <= sel_size;
            rw_q          <= sel_rw;
            id_q          <= sel_id;
            rr_ptr_q      <= rr_ptr_d;
            trans_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (trans_ready_i) begin
            trans_valid_q <= 1'b0;
            timer_q       <= '0;
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (trans_done_i) begin
            done_q[id_q] <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (TIMEOUT_EN && timer_q == TMR_LAST) begin
            timeout_q <= 1'b1;
            err_id_q  <= id_q;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trans_valid_o      = trans_valid_q;
  assign trans_hyper_addr_o = haddr_q;
  assign trans_l2_addr_o    = l2_q;
  assign trans_size_o       = size_q;
  assign trans_rw_o         = rw_q;
  assign trans_id_o         = id_q;
  assign done_o             = done_q;
  assign timeout_o          = timeout_q;
  assign err_id_o           = err_id_q;
  assign busy_o             = busy_q;
  assign nb_trans_waiting_o = nb_waiting;

endmodule
`default_nettype wire

// File: tb/tb_udma_hyper_trans_sched.sv
`default_nettype none
// Bench for udma_hyper_trans_sched: two requesters, 8-cycle done timeout, random descriptors.
module tb_udma_hyper_trans_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_haddr = '0;
  logic [23:0] req_l2 = '0;
  logic [31:0] req_size = '0;
  logic [1:0]  req_rw = '0;
  logic        trans_valid, trans_ready = 1'b0, trans_rw, trans_id, trans_done = 1'b0;
  logic [31:0] trans_haddr;
  logic [11:0] trans_l2;
  logic [15:0] trans_size;
  logic [1:0]  done;
  logic        timeout, err_id, busy;
  logic [1:0]  nb_wait;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  bit [31:0] d_addr [2];
  bit [11:0] d_l2   [2];
  bit [15:0] d_size [2];
  bit        d_rw   [2];

  udma_hyper_trans_sched #(
    .NB_CH(2), .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_hyper_addr_i(req_haddr), .req_l2_addr_i(req_l2),
    .req_size_i(req_size), .req_rw_i(req_rw),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .trans_hyper_addr_o(trans_haddr), .trans_l2_addr_o(trans_l2),
    .trans_size_o(trans_size), .trans_rw_o(trans_rw), .trans_id_o(trans_id),
    .trans_done_i(trans_done), .done_o(done), .timeout_o(timeout),
    .err_id_o(err_id), .busy_o(busy), .nb_trans_waiting_o(nb_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic new_desc(input int c);
    d_addr[c] = $urandom;
    d_l2[c]   = 12'($urandom);
    d_size[c] = 16'($urandom);
    d_rw[c]   = 1'($urandom);
  endtask

  task automatic drive_desc();
    for (int c = 0; c < 2; c++) begin
      req_haddr[c*32 +: 32] = d_addr[c];
      req_l2[c*12 +: 12]    = d_l2[c];
      req_size[c*16 +: 16]  = d_size[c];
      req_rw[c]             = d_rw[c];
    end
  endtask

  function automatic logic [61:0] exp_fields(input int c);
    return {d_addr[c], d_l2[c], d_size[c], d_rw[c], 1'(c)};
  endfunction

  function automatic logic [61:0] dut_fields();
    return {trans_haddr, trans_l2, trans_size, trans_rw, trans_id};
  endfunction

  // Reference arbiter: first requesting channel found walking up from the pointer.
  function automatic int model_grant(input logic [1:0] v);
    for (int k = 0; k < 2; k++) begin
      if (v[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    #1;
    checks++;
    if ({trans_valid, busy, done, timeout, err_id, req_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {trans_valid, busy, done, timeout, err_id, req_ready});
    end
    checks++;
    if (dut_fields() !== 62'b0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0", dut_fields());
    end
    checks++;
    if (nb_wait !== 2'd0) begin
      errors++;
      $display("FAIL reset_nb_wait: got %0d expected 0", nb_wait);
    end
  endtask

  task automatic test_single();
    int g;
    logic [61:0] exp;
    new_desc(1);
    d_addr[1] = 32'h1000; d_size[1] = 16'h40; d_rw[1] = 1'b1;
    drive_desc();
    req_valid = 2'b10;
    #1;
    g = model_grant(req_valid);
    checks++;
    if (req_ready !== 2'b10 || g != 1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 10", req_ready);
    end
    checks++;
    if (nb_wait !== 2'd1) begin
      errors++;
      $display("FAIL single_nb_wait: got %0d expected 1", nb_wait);
    end
    m_ptr = (g + 1) % 2;
    exp = exp_fields(1);
    tick();
    req_valid = 2'b00;
    trans_ready = 1'b1;
    #1;
    checks++;
    if ({trans_valid, busy, req_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL single_issue: got %b expected 1100", {trans_valid, busy, req_ready});
    end
    checks++;
    if (dut_fields() !== exp) begin
      errors++;
      $display("FAIL single_fields: got %h expected %h", dut_fields(), exp);
    end
    tick();
    trans_ready = 1'b0;
    repeat (4) tick();
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    #1;
    checks++;
    if ({done, busy, trans_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL single_done: got %b expected 1000", {done, busy, trans_valid});
    end
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse: got %b expected 00", done);
    end
  endtask

  task automatic test_round_robin();
    int g, r, w;
    logic [61:0] exp;
    logic [3:0] order;
    new_desc(0); new_desc(1);
    d_size[0] = 16'h0;
    drive_desc();
    for (int n = 0; n < 4; n++) begin
      req_valid = 2'b11;
      #1;
      g = model_grant(2'b11);
      checks++;
      if (req_ready !== (2'b01 << g) || nb_wait !== 2'd2) begin
        errors++;
        $display("FAIL rr_grant%0d: got ready=%b nb=%0d expected ready=%b nb=2", n, req_ready, nb_wait, 2'b01 << g);
      end
      exp = exp_fields(g);
      m_ptr = (g + 1) % 2;
      tick();
      order[n] = trans_id;
      new_desc(g);
      drive_desc();
      r = $urandom_range(0, 3);
      for (int k = 0; k <= r; k++) begin
        trans_ready = (k == r);
        #1;
        checks++;
        if (trans_valid !== 1'b1 || dut_fields() !== exp) begin
          errors++;
          $display("FAIL rr_issue%0d: got v=%b %h expected v=1 %h", n, trans_valid, dut_fields(), exp);
        end
        tick();
      end
      trans_ready = 1'b0;
      w = $urandom_range(0, 3);
      for (int k = 0; k <= w; k++) begin
        trans_done = (k == w);
        #1;
        checks++;
        if ({trans_valid, req_ready, done} !== 5'b0) begin
          errors++;
          $display("FAIL rr_wait%0d: got %b expected 00000", n, {trans_valid, req_ready, done});
        end
        tick();
      end
      trans_done = 1'b0;
      #1;
      checks++;
      if (done !== (2'b01 << g) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_done%0d: got done=%b busy=%b expected done=%b busy=0", n, done, busy, 2'b01 << g);
      end
    end
    req_valid = 2'b00;
    checks++;
    if (order !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order: got %b expected 1010 (0,1,0,1)", order);
    end
  endtask

  task automatic test_issue_stall();
    int g;
    logic [61:0] exp;
    new_desc(0);
    drive_desc();
    req_valid = 2'b01;
    #1;
    g = model_grant(req_valid);
    m_ptr = (g + 1) % 2;
    exp = exp_fields(g);
    tick();
    req_valid = 2'b00;
    new_desc(0);
    drive_desc();
    for (int k = 0; k < 10; k++) begin
      trans_done = (k % 3 == 2) || (k == 9);
      #1;
      checks++;
      if (trans_valid !== 1'b1 || dut_fields() !== exp || done !== 2'b00) begin
        errors++;
        $display("FAIL stall%0d: got v=%b %h done=%b expected v=1 %h done=00", k, trans_valid, dut_fields(), done, exp);
      end
      tick();
    end
    trans_done = 1'b0;
    trans_ready = 1'b1;
    #1;
    checks++;
    if (done !== 2'b00 || trans_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_ignored_done: got done=%b v=%b expected done=00 v=1", done, trans_valid);
    end
    tick();
    trans_ready = 1'b0;
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    #1;
    checks++;
    if (done !== (2'b01 << g)) begin
      errors++;
      $display("FAIL stall_done: got %b expected %b", done, 2'b01 << g);
    end
  endtask

  task automatic test_timeout();
    int g;
    logic [61:0] exp;
    new_desc(1);
    drive_desc();
    req_valid = 2'b10;
    #1;
    g = model_grant(req_valid);
    m_ptr = (g + 1) % 2;
    tick();
    req_valid = 2'b00;
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0;
    new_desc(0);
    drive_desc();
    req_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({timeout, req_ready, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL to_wait%0d: got %b expected 0001", k, {timeout, req_ready, busy});
      end
      tick();
    end
    #1;
    checks++;
    if ({timeout, err_id, done, busy} !== 5'b11000) begin
      errors++;
      $display("FAIL to_pulse: got %b expected 11000", {timeout, err_id, done, busy});
    end
    g = model_grant(req_valid);
    checks++;
    if (req_ready !== (2'b01 << g)) begin
      errors++;
      $display("FAIL to_next_ready: got %b expected %b", req_ready, 2'b01 << g);
    end
    m_ptr = (g + 1) % 2;
    exp = exp_fields(g);
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (timeout !== 1'b0 || dut_fields() !== exp) begin
      errors++;
      $display("FAIL to_next_issue: got to=%b %h expected to=0 %h", timeout, dut_fields(), exp);
    end
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0;
    repeat (7) tick();
    trans_done = 1'b1;
    #1;
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_before_last: got to=%b busy=%b expected to=0 busy=1", timeout, busy);
    end
    tick();
    trans_done = 1'b0;
    #1;
    checks++;
    if ({done, timeout, err_id} !== {2'b01 << g, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL to_done_wins: got %b expected %b", {done, timeout, err_id}, {2'b01 << g, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    int g;
    logic [61:0] exp;
    new_desc(0);
    drive_desc();
    req_valid = 2'b01;
    #1;
    g = model_grant(req_valid);
    m_ptr = (g + 1) % 2;
    tick();
    req_valid = 2'b00;
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0;
    tick();
    rst = 1'b1;
    trans_done = 1'b1;
    new_desc(1);
    drive_desc();
    req_valid = 2'b11;
    tick();
    trans_done = 1'b0;
    m_ptr = 0;
    #1;
    checks++;
    if ({trans_valid, busy, done, timeout, err_id, req_ready} !== 8'b0 || dut_fields() !== 62'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b %h expected all zero", {trans_valid, busy, done, timeout, err_id, req_ready}, dut_fields());
    end
    rst = 1'b0;
    #1;
    g = model_grant(req_valid);
    checks++;
    if (req_ready !== (2'b01 << g)) begin
      errors++;
      $display("FAIL rst_mid_grant: got %b expected %b", req_ready, 2'b01 << g);
    end
    m_ptr = (g + 1) % 2;
    exp = exp_fields(g);
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (dut_fields() !== exp || done !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_issue: got %h done=%b expected %h done=00", dut_fields(), done, exp);
    end
    trans_ready = 1'b1;
    tick();
    trans_ready = 1'b0;
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    #1;
    checks++;
    if (done !== (2'b01 << g)) begin
      errors++;
      $display("FAIL rst_mid_done: got %b expected %b", done, 2'b01 << g);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_issue_stall();
    test_timeout();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udma_hyper_trans_sched.md
# udma_hyper_trans_sched

Round-robin transaction scheduler placed in front of the uDMA HyperBus channel. It accepts transaction descriptors (HyperRAM address, L2 address, size, direction) from `NB_CH` independent requesters, such as per-ID register files. It issues them one at a time to the HyperBus controller over a valid/ready handshake and waits for completion before issuing the next. A done timeout reports and recovers from a controller that never completes.

## Interface
Parameters:
- `NB_CH`, 2: number of requesters, ≥2; `ID_W = $clog2(NB_CH)`, `CNT_W = $clog2(NB_CH+1)`.
- `L2_AWIDTH_NOAL`, 12: L2 address width.
- `TRANS_SIZE`, 16: size field width.
- `TIMEOUT_CYCLES`, 1024: done timeout in cycles. 0 disables the timeout.

Ports:
- `clk_i` in 1: clock. The block uses one clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in NB_CH: requester c has a descriptor pending.
- `req_ready_o` out NB_CH: accept strobe, one-hot or zero.
- `req_hyper_addr_i` in NB_CH*32: descriptor for channel c in slice [c*32 +: 32].
- `req_l2_addr_i` in NB_CH*L2_AWIDTH_NOAL: L2 start address, sliced likewise.
- `req_size_i` in NB_CH*TRANS_SIZE: size, sliced likewise.
- `req_rw_i` in NB_CH: 1 = read, 0 = write.
- `trans_valid_o` out 1: descriptor offered to the controller.
- `trans_ready_i` in 1: controller accepts.
- `trans_hyper_addr_o` out 32, `trans_l2_addr_o` out L2_AWIDTH_NOAL, `trans_size_o` out TRANS_SIZE, `trans_rw_o` out 1, `trans_id_o` out ID_W: latched descriptor and its channel.
- `trans_done_i` in 1: controller completion pulse.
- `done_o` out NB_CH: one-cycle completion pulse per channel.
- `timeout_o` out 1: one-cycle timeout pulse.
- `err_id_o` out ID_W: channel of the last timeout.
- `busy_o` out 1: a transaction is held (state ≠ IDLE).
- `nb_trans_waiting_o` out CNT_W: popcount(`req_valid_i`), combinational.

## Operation
- FSM states are IDLE, ISSUE and WAIT_DONE.
- Round-robin pointer `rr_ptr` (ID_W bits) gives highest priority to channel `rr_ptr`, then `rr_ptr+1`, and so on, modulo NB_CH.
- IDLE:
  - If any `req_valid_i` is high, select channel g by round-robin from `rr_ptr`.
  - Drive `req_ready_o[g]=1` combinationally in this cycle.
  - At the edge: latch g's descriptor and g into `trans_*_o`, set `rr_ptr <= (g+1) mod NB_CH`, and go to ISSUE.
  - With no requests, stay in IDLE with `req_ready_o=0`.
- ISSUE:
  - `trans_valid_o=1`; all `trans_*_o` fields stay stable.
  - On `trans_ready_i=1`, go to WAIT_DONE and clear the timer.
  - `trans_done_i` is ignored in this state.
- WAIT_DONE:
  - The timer increments every cycle.
  - On `trans_done_i`: go to IDLE and register `done_o[trans_id_o]=1` for one cycle.
  - If `TIMEOUT_CYCLES≠0` and the timer equals `TIMEOUT_CYCLES-1` with no done: go to IDLE, register `timeout_o=1` for one cycle, and set `err_id_o <= trans_id_o`.
  - Done and timeout in the same cycle: done wins and no timeout is raised.
- Descriptor fields are not interpreted. Size 0 is passed through unchanged.
- `req_ready_o` is never asserted outside IDLE. Requesters keep `req_valid_i` and their descriptor stable until accepted.
- `trans_*_o` fields hold their last latched value in IDLE and WAIT_DONE.
- Timer width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. No wrap is possible because the timer resets when WAIT_DONE is entered.

## Timing
- Reset values:
  - State IDLE, `rr_ptr=0`.
  - Outputs `trans_valid_o=0`, `trans_*_o=0`, `done_o=0`, `timeout_o=0`, `err_id_o=0`, `busy_o=0`, `req_ready_o=0`.
- Reset mid-transaction: the in-flight descriptor is dropped with no `done_o` or timeout. `trans_valid_o` is low from the first cycle after the reset edge.
- Request accepted in cycle T gives `trans_valid_o=1` in T+1 at the earliest.
- Handshake: a transfer happens in a cycle where `trans_valid_o & trans_ready_i`. `trans_ready_i` held high gives a 1-cycle ISSUE.
- `trans_done_i` in cycle D (WAIT_DONE) gives `done_o` pulse in D+1, with IDLE in D+1, so the next `req_ready_o` can appear in D+1.
- Minimum period between back-to-back transactions is 3 cycles: IDLE, then ISSUE, then one or more WAIT_DONE cycles.
- Timeout: WAIT_DONE entered at edge E gives `timeout_o` in cycle E+TIMEOUT_CYCLES.
- `busy_o` is 1 exactly in the ISSUE and WAIT_DONE cycles.

## Test plan
- Reset, then ch1 alone requests (addr 0x1000, size 0x40, rw=1). Expect: `req_ready_o=2'b10` in the same cycle; next cycle `trans_valid_o=1` with `trans_id_o=1` and the matching fields. With `trans_ready_i` high and `trans_done_i` 5 cycles later, expect `done_o=2'b10` one cycle after done and `busy_o` dropping.
- Both channels request continuously for 4 transactions. Expect grant order 0,1,0,1 and `nb_trans_waiting_o=2`; `trans_valid_o` never reasserts before the previous done.
- Hold `trans_ready_i=0` for 10 cycles in ISSUE. Expect `trans_valid_o` and all fields stable, and `trans_done_i` pulses during ISSUE ignored (no `done_o`).
- `TIMEOUT_CYCLES=8` with no done. Expect `timeout_o` exactly 8 cycles after WAIT_DONE entry, `err_id_o`=granted channel, no `done_o`, and the next request accepted in the same cycle as `timeout_o`. Repeat with done in the 8th cycle: `done_o` asserted, no timeout.
- Assert `rst_i` during WAIT_DONE. Expect all outputs at reset values next cycle and `rr_ptr=0`: with both channels requesting, ch0 is granted first.
